// File: rtl/gemm_pkg.sv
// Shared types and constants for the GEMM tile sequencer.
//   state_e      : sequencer FSM states
//   ARRAY_I/J    : default systolic array geometry (rows / columns)
//   DRAIN_CYCLES : pipeline drain length for the default geometry (SRAM latency + skew)
//   ceil_div     : ceiling division on 33-bit operands, wide enough that a 16-bit
//                  dimension of 2^16-1 cannot overflow the rounding add
package gemm_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StFeed,
    StDrain,
    StDone,
    StErr
  } state_e;

  localparam int unsigned ARRAY_I      = 4;
  localparam int unsigned ARRAY_J      = 4;
  localparam int unsigned DRAIN_CYCLES = ARRAY_I + ARRAY_J;

  function automatic logic [32:0] ceil_div(input logic [32:0] a, input logic [32:0] b);
    ceil_div = (a + b - 33'd1) / b;
  endfunction

endpackage

// File: rtl/gemm_addr_gen.sv
// Ifmap/filter SRAM read address generator for the GEMM tile sequencer.
// Holds the per-tile base addresses mt*K and nt*K, stepped by +K on tile advance
// (no multiplier), and registers base + kk when asked to.
// Ports:
//   i_clk, i_rst     : clock, synchronous active-high reset
//   i_k              : latched reduction length K
//   i_clear          : job accepted, zero both bases
//   i_next_n         : advance to next column tile (n base += K)
//   i_next_m         : advance to next row tile (n base = 0, m base += K)
//   i_load, i_kk     : load address registers with base + i_kk
//   o_ifmaps_addr    : ifmap SRAM read address (wraps modulo 2^SRAM_ADDR_WIDTH)
//   o_filters_addr   : filter SRAM read address (wraps modulo 2^SRAM_ADDR_WIDTH)
module gemm_addr_gen #(
  parameter int unsigned WIDTH           = 16,
  parameter int unsigned SRAM_ADDR_WIDTH = 10
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [WIDTH-1:0]           i_k,
  input  logic                       i_clear,
  input  logic                       i_next_n,
  input  logic                       i_next_m,
  input  logic                       i_load,
  input  logic [WIDTH-1:0]           i_kk,
  output logic [SRAM_ADDR_WIDTH-1:0] o_ifmaps_addr,
  output logic [SRAM_ADDR_WIDTH-1:0] o_filters_addr
);

  logic [SRAM_ADDR_WIDTH-1:0] r_m_base;
  logic [SRAM_ADDR_WIDTH-1:0] r_n_base;
  logic [SRAM_ADDR_WIDTH-1:0] r_if_addr;
  logic [SRAM_ADDR_WIDTH-1:0] r_f_addr;
  logic [SRAM_ADDR_WIDTH-1:0] w_k;
  logic [SRAM_ADDR_WIDTH-1:0] w_kk;

  // Only the low address bits matter: the address space wraps silently.
  assign w_k  = SRAM_ADDR_WIDTH'(i_k);
  assign w_kk = SRAM_ADDR_WIDTH'(i_kk);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_m_base  <= '0;
      r_n_base  <= '0;
      r_if_addr <= '0;
      r_f_addr  <= '0;
    end else begin
      if (i_clear) begin
        r_m_base <= '0;
        r_n_base <= '0;
      end else if (i_next_m) begin
        r_n_base <= '0;
        r_m_base <= r_m_base + w_k;
      end else if (i_next_n) begin
        r_n_base <= r_n_base + w_k;
      end
      // Outside FEED the addresses hold their last value.
      if (i_load) begin
        r_if_addr <= r_m_base + w_kk;
        r_f_addr  <= r_n_base + w_kk;
      end
    end
  end

  assign o_ifmaps_addr  = r_if_addr;
  assign o_filters_addr = r_f_addr;

endmodule

// File: rtl/gemm_tile_sequencer.sv
// GEMM tile sequencer: runs C[m x n] = A[m x k] * B[k x n] on an I x J systolic array.
// Tiles m by I (outer loop) and n by J (inner loop); per tile it clears the array (LOAD),
// streams K SRAM reads (FEED), then waits I+J cycles for the pipeline to drain (DRAIN).
// Optional feature: define GEMM_SEQ_PERF_EN to add o_perf_cycles / o_perf_tiles counters.
// Ports:
//   i_clk, i_rst               : clock, synchronous active-high reset (wins over start)
//   i_start                    : job request, sampled only in IDLE
//   i_k, i_m, i_n              : GEMM dimensions, latched on an accepted start
//   o_busy                     : accepted start through the DONE/ERR cycle
//   o_done, o_err              : job-finished pulse; err pulses with done on a zero dim
//   o_ifmaps_addr/filters_addr : SRAM read addresses
//   o_enable_*_to_sa           : SRAM read data valid for the array edges (FEED delayed 1)
//   o_sa_clear                 : clear array accumulators (one pulse per tile)
//   o_tile_done                : current tile result stable in the array
//   o_tile_m_idx/n_idx         : current tile indices, 0 when idle
//   o_perf_cycles/perf_tiles   : busy-cycle and tile counters (GEMM_SEQ_PERF_EN only)
module gemm_tile_sequencer
  import gemm_pkg::*;
#(
  parameter int unsigned WIDTH           = 16,
  parameter int unsigned SRAM_ADDR_WIDTH = 10,
  parameter int unsigned I               = ARRAY_I,
  parameter int unsigned J               = ARRAY_J
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_start,
  input  logic [WIDTH-1:0]           i_k,
  input  logic [WIDTH-1:0]           i_m,
  input  logic [WIDTH-1:0]           i_n,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_err,
  output logic [SRAM_ADDR_WIDTH-1:0] o_ifmaps_addr,
  output logic [SRAM_ADDR_WIDTH-1:0] o_filters_addr,
  output logic                       o_enable_ifmaps_to_sa,
  output logic                       o_enable_filters_to_sa,
  output logic                       o_sa_clear,
  output logic                       o_tile_done,
  output logic [WIDTH-1:0]           o_tile_m_idx,
  output logic [WIDTH-1:0]           o_tile_n_idx
`ifdef GEMM_SEQ_PERF_EN
  ,
  output logic [31:0]                o_perf_cycles,
  output logic [WIDTH-1:0]           o_perf_tiles
`endif
);

  // One SRAM read latency plus I+J-1 cycles of systolic skew.
  localparam int unsigned DrainCycles = I + J;
  localparam int unsigned DrainW      = $clog2(DrainCycles) + 1;

  state_e            r_state;
  logic [WIDTH-1:0]  r_k;
  logic [WIDTH-1:0]  r_mt_total;
  logic [WIDTH-1:0]  r_nt_total;
  logic [WIDTH-1:0]  r_mt;
  logic [WIDTH-1:0]  r_nt;
  logic [WIDTH-1:0]  r_kk;
  logic [DrainW-1:0] r_drain_left;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic              r_sa_clear;
  logic              r_tile_done;
  logic              r_feed_en;

  logic              w_accept;
  logic              w_zero_dim;
  logic [WIDTH-1:0]  w_mt_total;
  logic [WIDTH-1:0]  w_nt_total;
  logic              w_kk_last;
  logic              w_drain_end;
  logic              w_last_n;
  logic              w_last_m;
  logic              w_next_n;
  logic              w_next_m;
  logic              w_addr_load;
  logic [WIDTH-1:0]  w_kk_next;

  assign w_accept   = (r_state == StIdle) && i_start;
  assign w_zero_dim = (i_k == '0) || (i_m == '0) || (i_n == '0);
  // 33-bit intermediates keep m = 2^WIDTH-1 from overflowing the rounding add.
  assign w_mt_total = WIDTH'(ceil_div(33'(i_m), 33'(I)));
  assign w_nt_total = WIDTH'(ceil_div(33'(i_n), 33'(J)));

  assign w_kk_last   = (r_kk == r_k - WIDTH'(1));
  assign w_drain_end = (r_state == StDrain) && (r_drain_left == '0);
  assign w_last_n    = (r_nt == r_nt_total - WIDTH'(1));
  assign w_last_m    = (r_mt == r_mt_total - WIDTH'(1));
  assign w_next_n    = w_drain_end && !w_last_n;
  assign w_next_m    = w_drain_end && w_last_n && !w_last_m;

  // Address registers load on every edge that lands in a FEED cycle.
  assign w_addr_load = (r_state == StLoad) || ((r_state == StFeed) && !w_kk_last);
  assign w_kk_next   = (r_state == StLoad) ? '0 : r_kk + WIDTH'(1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= StIdle;
      r_k          <= '0;
      r_mt_total   <= '0;
      r_nt_total   <= '0;
      r_mt         <= '0;
      r_nt         <= '0;
      r_kk         <= '0;
      r_drain_left <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_sa_clear   <= 1'b0;
      r_tile_done  <= 1'b0;
      r_feed_en    <= 1'b0;
    end else begin
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_sa_clear  <= 1'b0;
      r_tile_done <= 1'b0;
      // Matches the 1-cycle SRAM read latency.
      r_feed_en   <= (r_state == StFeed);
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_k        <= i_k;
            r_mt_total <= w_mt_total;
            r_nt_total <= w_nt_total;
            r_mt       <= '0;
            r_nt       <= '0;
            r_busy     <= 1'b1;
            if (w_zero_dim) begin
              r_state <= StErr;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end else begin
              r_state    <= StLoad;
              r_sa_clear <= 1'b1;
            end
          end
        end
        StLoad: begin
          r_state <= StFeed;
          r_kk    <= w_kk_next;
        end
        StFeed: begin
          if (w_kk_last) begin
            r_state      <= StDrain;
            r_drain_left <= DrainW'(DrainCycles - 1);
            r_tile_done  <= (DrainCycles == 1);
          end else begin
            r_kk <= w_kk_next;
          end
        end
        StDrain: begin
          if (w_drain_end) begin
            if (w_last_n && w_last_m) begin
              r_state <= StDone;
              r_done  <= 1'b1;
            end else begin
              r_state    <= StLoad;
              r_sa_clear <= 1'b1;
              if (w_last_n) begin
                r_nt <= '0;
                r_mt <= r_mt + WIDTH'(1);
              end else begin
                r_nt <= r_nt + WIDTH'(1);
              end
            end
          end else begin
            r_drain_left <= r_drain_left - DrainW'(1);
            r_tile_done  <= (r_drain_left == DrainW'(1));
          end
        end
        StDone, StErr: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
          r_mt    <= '0;
          r_nt    <= '0;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  gemm_addr_gen #(
    .WIDTH           (WIDTH),
    .SRAM_ADDR_WIDTH (SRAM_ADDR_WIDTH)
  ) u_addr_gen (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_k            (r_k),
    .i_clear        (w_accept),
    .i_next_n       (w_next_n),
    .i_next_m       (w_next_m),
    .i_load         (w_addr_load),
    .i_kk           (w_kk_next),
    .o_ifmaps_addr  (o_ifmaps_addr),
    .o_filters_addr (o_filters_addr)
  );

`ifdef GEMM_SEQ_PERF_EN
  logic [31:0]      r_perf_cycles;
  logic [WIDTH-1:0] r_perf_tiles;

  // r_busy is low in IDLE, so clearing on accept never collides with counting.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_perf_cycles <= '0;
      r_perf_tiles  <= '0;
    end else if (w_accept) begin
      r_perf_cycles <= '0;
      r_perf_tiles  <= '0;
    end else begin
      if (r_busy && (r_perf_cycles != '1)) begin
        r_perf_cycles <= r_perf_cycles + 32'd1;
      end
      if (r_tile_done) begin
        r_perf_tiles <= r_perf_tiles + WIDTH'(1);
      end
    end
  end

  assign o_perf_cycles = r_perf_cycles;
  assign o_perf_tiles  = r_perf_tiles;
`endif

  assign o_busy                 = r_busy;
  assign o_done                 = r_done;
  assign o_err                  = r_err;
  assign o_enable_ifmaps_to_sa  = r_feed_en;
  assign o_enable_filters_to_sa = r_feed_en;
  assign o_sa_clear             = r_sa_clear;
  assign o_tile_done            = r_tile_done;
  assign o_tile_m_idx           = r_mt;
  assign o_tile_n_idx           = r_nt;

endmodule

// File: tb/tb_gemm_tile_sequencer.sv
// Scoreboard bench for gemm_tile_sequencer (I=J=4, SRAM_ADDR_WIDTH=10).
// Cycle numbering: cyc is incremented at every rising edge; a start sampled at edge s puts
// LOAD in period s. The job model enumerates tiles and reads with plain loops and pushes
// timed events; the negedge monitor pops and compares whenever the DUT shows one.
module tb_gemm_tile_sequencer;

  localparam int ArrI  = 4;
  localparam int ArrJ  = 4;
  localparam int AMod  = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] k, m, n;
  logic        busy, done, err, en_if, en_f, sa_clear, tile_done;
  logic [9:0]  if_addr, f_addr;
  logic [15:0] tile_m, tile_n;
`ifdef GEMM_SEQ_PERF_EN
  logic [31:0] perf_cycles;
  logic [15:0] perf_tiles;
`endif

  gemm_tile_sequencer #(
    .WIDTH           (16),
    .SRAM_ADDR_WIDTH (10),
    .I               (4),
    .J               (4)
  ) dut (
    .i_clk                  (clk),
    .i_rst                  (rst),
    .i_start                (start),
    .i_k                    (k),
    .i_m                    (m),
    .i_n                    (n),
    .o_busy                 (busy),
    .o_done                 (done),
    .o_err                  (err),
    .o_ifmaps_addr          (if_addr),
    .o_filters_addr         (f_addr),
    .o_enable_ifmaps_to_sa  (en_if),
    .o_enable_filters_to_sa (en_f),
    .o_sa_clear             (sa_clear),
    .o_tile_done            (tile_done),
    .o_tile_m_idx           (tile_m),
    .o_tile_n_idx           (tile_n)
`ifdef GEMM_SEQ_PERF_EN
    ,
    .o_perf_cycles          (perf_cycles),
    .o_perf_tiles           (perf_tiles)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int a;
    int b;
  } ev_t;

  ev_t q_feed[$];
  ev_t q_clr[$];
  ev_t q_tile[$];
  ev_t q_done[$];

  int checks = 0;
  int errors = 0;
  bit mon_on = 1'b0;
  int prev_if = 0;
  int prev_f  = 0;

  task automatic check(input string name, input bit ok, input string detail);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  task automatic pop_ev(input int kind, output bit found, output ev_t e);
    found = 1'b1;
    case (kind)
      0: if (q_feed.size() > 0) e = q_feed.pop_front(); else found = 1'b0;
      1: if (q_clr.size() > 0)  e = q_clr.pop_front();  else found = 1'b0;
      2: if (q_tile.size() > 0) e = q_tile.pop_front(); else found = 1'b0;
      default: if (q_done.size() > 0) e = q_done.pop_front(); else found = 1'b0;
    endcase
  endtask

  task automatic expect_ev(input int kind, input string name, input int a, input int b,
                           input bit side_ok);
    ev_t e;
    bit  found;
    pop_ev(kind, found, e);
    if (!found) begin
      check(name, 1'b0, $sformatf("got event cyc=%0d a=%0d b=%0d, required none", cyc, a, b));
    end else begin
      check(name, (e.cyc == cyc) && (e.a == a) && (e.b == b) && side_ok,
            $sformatf("got cyc=%0d a=%0d b=%0d side=%0b, required cyc=%0d a=%0d b=%0d side=1",
                      cyc, a, b, side_ok, e.cyc, e.a, e.b));
    end
  endtask

  // Monitor: each enable cycle delivers the address presented one cycle earlier.
  always @(negedge clk) begin
    if (mon_on) begin
      if (en_if || en_f) expect_ev(0, "feed", prev_if, prev_f, en_if && en_f);
      if (sa_clear) expect_ev(1, "sa_clear", int'(tile_m), int'(tile_n), busy);
      if (tile_done) expect_ev(2, "tile_done", int'(tile_m), int'(tile_n), busy);
      if (done) expect_ev(3, "done", int'(err), 0, busy);
      else if (err) check("err_without_done", 1'b0, "got err=1 done=0, required err only with done");
    end
    prev_if <= int'(if_addr);
    prev_f  <= int'(f_addr);
  end

  // Reference model: a job of MT*NT tiles, each 1+K+I+J cycles, walked row-major.
  task automatic model(input int s, input int kv, input int mv, input int nv,
                       output int total, output int ntiles);
    int mtn, ntn, p, t;
    if (kv == 0 || mv == 0 || nv == 0) begin
      q_done.push_back(ev_t'{s, 1, 0});
      total  = 1;
      ntiles = 0;
      return;
    end
    mtn = (mv + ArrI - 1) / ArrI;
    ntn = (nv + ArrJ - 1) / ArrJ;
    p   = 1 + kv + ArrI + ArrJ;
    t   = 0;
    for (int mi = 0; mi < mtn; mi++) begin
      for (int ni = 0; ni < ntn; ni++) begin
        q_clr.push_back(ev_t'{s + t * p, mi, ni});
        for (int kk = 0; kk < kv; kk++) begin
          q_feed.push_back(ev_t'{s + t * p + 2 + kk, (mi * kv + kk) % AMod,
                                 (ni * kv + kk) % AMod});
        end
        q_tile.push_back(ev_t'{s + (t + 1) * p - 1, mi, ni});
        t++;
      end
    end
    q_done.push_back(ev_t'{s + t * p, 0, 0});
    total  = t * p + 1;
    ntiles = t;
  endtask

  function automatic bit outs_zero();
    return !(busy || done || err || sa_clear || tile_done || en_if || en_f) &&
           (if_addr == 10'd0) && (f_addr == 10'd0) && (tile_m == 16'd0) && (tile_n == 16'd0);
  endfunction

  function automatic string outs_str();
    return $sformatf("busy=%0b done=%0b err=%0b clr=%0b td=%0b en=%0b%0b addr=%0d/%0d idx=%0d/%0d",
                     busy, done, err, sa_clear, tile_done, en_if, en_f, if_addr, f_addr,
                     tile_m, tile_n);
  endfunction

  task automatic run_job(input int kv, input int mv, input int nv, input bit spurious);
    int s, total, ntiles, r;
    @(negedge clk);
    k     = 16'(kv);
    m     = 16'(mv);
    n     = 16'(nv);
    start = 1'b1;
    s     = cyc + 1;
    model(s, kv, mv, nv, total, ntiles);
    @(negedge clk);
    start = 1'b0;
    if (spurious && total > 2) begin
      r = $urandom_range(total - 1, 1);
      repeat (r - 1) @(negedge clk);
      start = 1'b1;
      k     = 16'($urandom_range(20, 0));
      m     = 16'($urandom_range(20, 0));
      n     = 16'($urandom_range(20, 0));
      @(negedge clk);
      start = 1'b0;
    end
    while (cyc < s + total + 2) @(negedge clk);
    check("idle_after_job", !busy && tile_m == 16'd0 && tile_n == 16'd0,
          $sformatf("got busy=%0b idx=%0d/%0d, required 0 0/0", busy, tile_m, tile_n));
`ifdef GEMM_SEQ_PERF_EN
    check("perf_cycles", perf_cycles == 32'(total),
          $sformatf("got %0d, required %0d", perf_cycles, total));
    check("perf_tiles", perf_tiles == 16'(ntiles),
          $sformatf("got %0d, required %0d", perf_tiles, ntiles));
`endif
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: got no end of test, required finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s;
    rst   = 1'b1;
    start = 1'b0;
    k     = '0;
    m     = '0;
    n     = '0;
    repeat (3) @(negedge clk);
    check("reset_state", outs_zero(), $sformatf("got %s, required all zero", outs_str()));
    rst    = 1'b0;
    mon_on = 1'b1;
    repeat (2) @(negedge clk);

    run_job(3, 4, 4, 1'b0);     // single tile
    run_job(2, 8, 5, 1'b0);     // 2x2 tiles, partial n tile
    run_job(3, 0, 4, 1'b0);     // zero dim -> err
    run_job(0, 5, 5, 1'b0);
    run_job(600, 8, 4, 1'b0);   // ifmap address wrap on mt=1
    run_job(3, 4, 8, 1'b1);     // start pulse while busy

    // Reset during the second FEED cycle aborts without done.
    @(negedge clk);
    k = 16'd5; m = 16'd4; n = 16'd4; start = 1'b1;
    s = cyc + 1;
    q_clr.push_back(ev_t'{s, 0, 0});
    q_feed.push_back(ev_t'{s + 2, 0, 0});
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("reset_mid_feed", outs_zero(), $sformatf("got %s, required all zero", outs_str()));
    repeat (20) @(negedge clk);
    run_job(4, 6, 6, 1'b0);

    // Reset wins over a simultaneous start.
    @(negedge clk);
    rst = 1'b1; start = 1'b1; k = 16'd2; m = 16'd4; n = 16'd4;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("reset_beats_start", outs_zero(), $sformatf("got %s, required all zero", outs_str()));
    repeat (20) @(negedge clk);

    for (int j = 0; j < 25; j++) begin
      int kv, mv, nv;
      kv = ($urandom_range(9, 0) == 0) ? 0 : int'($urandom_range(16, 1));
      mv = int'($urandom_range(12, 0));
      nv = int'($urandom_range(12, 0));
      run_job(kv, mv, nv, 1'($urandom_range(1, 0)));
    end

    repeat (5) @(negedge clk);
    check("feed_queue_empty", q_feed.size() == 0,
          $sformatf("got %0d left, required 0", q_feed.size()));
    check("clear_queue_empty", q_clr.size() == 0,
          $sformatf("got %0d left, required 0", q_clr.size()));
    check("tile_queue_empty", q_tile.size() == 0,
          $sformatf("got %0d left, required 0", q_tile.size()));
    check("done_queue_empty", q_done.size() == 0,
          $sformatf("got %0d left, required 0", q_done.size()));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
